// File: rtl/i2s_rx_stream_if.sv
// -----------------------------------------------------------------------------
// i2s_rx_stream_if
// Sample stream between the I2S capture master and the downstream DSP.
//   left, right   : captured stereo pair (two's complement)
//   sample_valid  : left/right hold a frame not yet consumed
//   sample_ready  : consumer accepts the frame when valid && ready
//   mono          : (left+right)/2, present only when I2S_RX_MONO_EN is defined
// master modport = producer (capture block), slave modport = consumer.
// -----------------------------------------------------------------------------
interface i2s_rx_stream_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
    logic              sample_valid;
    logic              sample_ready;
`ifdef I2S_RX_MONO_EN
    logic [DATA_W-1:0] mono;

    modport master (output left, output right, output sample_valid, output mono,
                    input sample_ready);
    modport slave  (input left, input right, input sample_valid, input mono,
                    output sample_ready);
`else
    modport master (output left, output right, output sample_valid,
                    input sample_ready);
    modport slave  (input left, input right, input sample_valid,
                    output sample_ready);
`endif
endinterface

// File: rtl/i2s_rx_stream.sv
// -----------------------------------------------------------------------------
// i2s_rx_stream
// Stereo I2S / left-justified capture master for ADCs such as the PCM1808.
// All clocks for the ADC are derived from one free-running prescaler in the
// clk domain; din is sampled on the clk edge that raises bck, so nothing is
// clocked by bck itself.
//
// Ports
//   clk          system clock, forwarded unchanged as scki
//   reset        synchronous, active-low
//   en           1 = run bck/lrck and capture, 0 = idle (clocks parked low)
//   din          serial data from the ADC
//   scki         ADC system clock (= clk)
//   bck          bit clock, clk/BCK_DIV
//   lrck         word clock, 0 = left slot, 1 = right slot
//   overrun      sticky flag: a frame completed while the previous one was
//                still unconsumed
//   overrun_clr  clears overrun (a simultaneous new overrun wins)
//   stream       sample stream (left, right, sample_valid, sample_ready[, mono])
//
// Optional feature: define I2S_RX_MONO_EN to add stream.mono, the
// arithmetic mean of left and right, registered together with them.
// -----------------------------------------------------------------------------
module i2s_rx_stream #(
    parameter int DATA_W  = 24,
    parameter int SLOT_W  = 32,
    parameter int BCK_DIV = 4,
    parameter int MODE    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  din,
    output logic                  scki,
    output logic                  bck,
    output logic                  lrck,
    output logic                  overrun,
    input  logic                  overrun_clr,
    i2s_rx_stream_if.master       stream
);

    localparam int BW        = $clog2(BCK_DIV);
    localparam int PW        = $clog2(BCK_DIV * 2 * SLOT_W);
    localparam int SW        = PW - 1 - BW;
    // I2S puts the MSB one bck after the lrck edge, left-justified on it.
    localparam int FIRST_IDX = (MODE == 0) ? 1 : 0;
    localparam int LAST_IDX  = FIRST_IDX + DATA_W - 1;
    localparam logic [BW-1:0] STROBE_PH = BW'(BCK_DIV / 2 - 1);

    logic [PW-1:0]     prescaler_reg;
    logic [DATA_W-1:0] lsreg_reg;
    logic [DATA_W-1:0] rsreg_reg;
    logic [DATA_W-1:0] left_reg;
    logic [DATA_W-1:0] right_reg;
    logic              done_reg;
    logic              valid_reg;
    logic              overrun_reg;

    logic [SW-1:0]     bit_idx;
    logic              slot_r;
    logic              strobe;
    logic              capture;
    logic              frame_end;

    always_comb begin
        bit_idx   = prescaler_reg[PW-2:BW];
        slot_r    = prescaler_reg[PW-1];
        strobe    = en && (prescaler_reg[BW-1:0] == STROBE_PH);
        capture   = strobe && (int'(bit_idx) >= FIRST_IDX) && (int'(bit_idx) <= LAST_IDX);
        frame_end = capture && slot_r && (int'(bit_idx) == LAST_IDX);
    end

`ifdef I2S_RX_MONO_EN
    logic [DATA_W-1:0] mono_reg;
    logic [DATA_W:0]   mono_sum;

    // One extra bit holds the full sum; dropping its LSB is the >>>1.
    assign mono_sum = {lsreg_reg[DATA_W-1], lsreg_reg} + {rsreg_reg[DATA_W-1], rsreg_reg};
    assign stream.mono = mono_reg;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            prescaler_reg <= '0;
            lsreg_reg     <= '0;
            rsreg_reg     <= '0;
            left_reg      <= '0;
            right_reg     <= '0;
            done_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
`ifdef I2S_RX_MONO_EN
            mono_reg      <= '0;
`endif
        end else begin
            // Parking the counter at 0 while idle freezes the ADC clocks and
            // guarantees the next frame starts cleanly at the left slot.
            if (en) begin
                prescaler_reg <= prescaler_reg + PW'(1);
            end else begin
                prescaler_reg <= '0;
            end

            if (!en) begin
                lsreg_reg <= '0;
                rsreg_reg <= '0;
            end else if (capture) begin
                if (slot_r) begin
                    rsreg_reg <= {rsreg_reg[DATA_W-2:0], din};
                end else begin
                    lsreg_reg <= {lsreg_reg[DATA_W-2:0], din};
                end
            end

            // The last right bit lands in rsreg on the frame_end edge, so the
            // output registers are loaded one edge later.
            done_reg <= frame_end;

            if (done_reg) begin
                left_reg  <= lsreg_reg;
                right_reg <= rsreg_reg;
                valid_reg <= 1'b1;
`ifdef I2S_RX_MONO_EN
                mono_reg  <= mono_sum[DATA_W:1];
`endif
            end else if (stream.sample_ready) begin
                valid_reg <= 1'b0;
            end

            if (done_reg && valid_reg && !stream.sample_ready) begin
                overrun_reg <= 1'b1;
            end else if (overrun_clr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign scki                = clk;
    assign bck                 = prescaler_reg[BW-1];
    assign lrck                = prescaler_reg[PW-1];
    assign overrun             = overrun_reg;
    assign stream.left         = left_reg;
    assign stream.right        = right_reg;
    assign stream.sample_valid = valid_reg;

endmodule

// File: tb/tb_i2s_rx_stream.sv
// -----------------------------------------------------------------------------
// tb_i2s_rx_stream
// Two capture blocks share clk/reset/en: the default I2S build (24/32/4) and
// a left-justified 16-bit/16-slot build.  Each has a small ADC model that
// shifts its word out on falling bck, restarting its bit count on every lrck
// edge; bits outside the data window are driven 1 so misalignment shows up.
// Define I2S_RX_MONO_EN to also check the mono output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2s_rx_stream;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic overrun_clr;
    logic overrun_clr16;

    logic din24, scki24, bck24, lrck24, overrun24;
    logic din16, scki16, bck16, lrck16, overrun16;

    logic [23:0] l24, r24;
    logic [15:0] l16, r16;

    int total_cnt = 0;
    int bad_cnt   = 0;

    i2s_rx_stream_if #(.DATA_W(24)) s24 ();
    i2s_rx_stream_if #(.DATA_W(16)) s16 ();

    i2s_rx_stream dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .din         (din24),
        .scki        (scki24),
        .bck         (bck24),
        .lrck        (lrck24),
        .overrun     (overrun24),
        .overrun_clr (overrun_clr),
        .stream      (s24)
    );

    i2s_rx_stream #(.DATA_W(16), .SLOT_W(16), .BCK_DIV(4), .MODE(1)) dut16 (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .din         (din16),
        .scki        (scki16),
        .bck         (bck16),
        .lrck        (lrck16),
        .overrun     (overrun16),
        .overrun_clr (overrun_clr16),
        .stream      (s16)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    function automatic logic adc_bit(input int cnt, input int first, input int dw,
                                     input logic [31:0] word);
        int k;
        k = cnt - first;
        if (cnt >= first && k < dw) return word[dw-1-k];
        return 1'b1;
    endfunction

    // ADC models: react just after each clk edge to the DUT's bck/lrck.
    int   c24 = 0, c16 = 0;
    logic plr24 = 1'b0, pbck24 = 1'b0, plr16 = 1'b0, pbck16 = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!reset || !en) begin
            c24 = 0; plr24 = 1'b0;
        end else if (lrck24 != plr24) begin
            c24 = 0; plr24 = lrck24;
        end else if (pbck24 && !bck24) begin
            c24++;
        end
        pbck24 = bck24;
        din24  = adc_bit(c24, 1, 24, {8'h0, (lrck24 ? r24 : l24)});
    end

    always @(posedge clk) begin
        #1;
        if (!reset || !en) begin
            c16 = 0; plr16 = 1'b0;
        end else if (lrck16 != plr16) begin
            c16 = 0; plr16 = lrck16;
        end else if (pbck16 && !bck16) begin
            c16++;
        end
        pbck16 = bck16;
        din16  = adc_bit(c16, 0, 16, {16'h0, (lrck16 ? r16 : l16)});
    end

    initial begin
        int   rises;
        int   lr_low;
        logic prev_bck;

        reset = 1'b0; en = 1'b1; overrun_clr = 1'b0; overrun_clr16 = 1'b0;
        din24 = 1'b1; din16 = 1'b1;
        s24.sample_ready = 1'b0; s16.sample_ready = 1'b0;
        l24 = 24'h123456; r24 = 24'hABCDEF;
        l16 = 16'h8001;   r16 = 16'h7FFE;

        // Reset state
        repeat (4) @(negedge clk);
        check_val("rst_bck",     32'(bck24), 32'h0);
        check_val("rst_lrck",    32'(lrck24), 32'h0);
        check_val("rst_left",    32'(s24.left), 32'h0);
        check_val("rst_right",   32'(s24.right), 32'h0);
        check_val("rst_valid",   32'(s24.sample_valid), 32'h0);
        check_val("rst_overrun", 32'(overrun24), 32'h0);
        check_val("scki_low",    32'(scki24), 32'h0);

        // First frame with clock measurement (prescaler 0 at release)
        reset = 1'b1;
        rises = 0; lr_low = 0; prev_bck = bck24;
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            if (bck24 && !prev_bck) rises++;
            prev_bck = bck24;
            if (!lrck24) lr_low++;
            if (k == 1)   check_val("lrck_starts_low", 32'(lrck24), 32'h0);
            if (k == 128) check_val("lrck_high_at_128", 32'(lrck24), 32'h1);
        end
        check_val("bck_rises_per_frame", 32'(rises), 32'd64);
        check_val("lrck_low_clks",       32'(lr_low), 32'd128);
        check_val("f1_left",  32'(s24.left), 32'h123456);
        check_val("f1_right", 32'(s24.right), 32'hABCDEF);
        check_val("f1_valid", 32'(s24.sample_valid), 32'h1);

        // Second frame unconsumed -> overrun, freshest data wins
        l24 = 24'h0F0F0F; r24 = 24'h700001;
        repeat (256) @(negedge clk);
        check_val("ovr_flag",  32'(overrun24), 32'h1);
        check_val("ovr_left",  32'(s24.left), 32'h0F0F0F);
        check_val("ovr_right", 32'(s24.right), 32'h700001);
        check_val("ovr_valid", 32'(s24.sample_valid), 32'h1);
        check_val("lj_left",   32'(s16.left), 32'h8001);
        check_val("lj_right",  32'(s16.right), 32'h7FFE);
        check_val("lj_overrun", 32'(overrun16), 32'h1);

        // Clear overrun, then accept
        overrun_clr = 1'b1;
        @(negedge clk);
        check_val("ovr_cleared", 32'(overrun24), 32'h0);
        overrun_clr = 1'b0;
        s24.sample_ready = 1'b1;
        @(negedge clk);
        check_val("accept_valid_drop", 32'(s24.sample_valid), 32'h0);
        check_val("accept_left_hold",  32'(s24.left), 32'h0F0F0F);
        s24.sample_ready = 1'b0;

        // Reset at bit 10 of the left slot (prescaler 42)
        repeat (40) @(negedge clk);
        reset = 1'b0;
        l24 = 24'h7FFFFF; r24 = 24'h7FFFFF;
        @(negedge clk);
        check_val("mid_rst_left",  32'(s24.left), 32'h0);
        check_val("mid_rst_right", 32'(s24.right), 32'h0);
        check_val("mid_rst_valid", 32'(s24.sample_valid), 32'h0);
        check_val("mid_rst_bck",   32'(bck24), 32'h0);
        check_val("mid_rst_lrck",  32'(lrck24), 32'h0);
        check_val("mid_rst_lj_left", 32'(s16.left), 32'h0);
        reset = 1'b1;
        repeat (256) @(negedge clk);
        check_val("post_rst_left",  32'(s24.left), 32'h7FFFFF);
        check_val("post_rst_right", 32'(s24.right), 32'h7FFFFF);
        check_val("post_rst_valid", 32'(s24.sample_valid), 32'h1);
        check_val("post_rst_ovr",   32'(overrun24), 32'h0);
        check_val("post_rst_lj_left",  32'(s16.left), 32'h8001);
        check_val("post_rst_lj_right", 32'(s16.right), 32'h7FFE);
`ifdef I2S_RX_MONO_EN
        check_val("mono_max", 32'(s24.mono), 32'h7FFFFF);
`endif

        // Consume, then drop en in the middle of the right slot
        s24.sample_ready = 1'b1;
        @(negedge clk);
        check_val("accept2_valid", 32'(s24.sample_valid), 32'h0);
        s24.sample_ready = 1'b0;
        l24 = 24'h111111; r24 = 24'h222222;
        repeat (150) @(negedge clk);
        en = 1'b0;
        l24 = 24'h800000; r24 = 24'h000000;
        repeat (10) @(negedge clk);
        check_val("idle_valid", 32'(s24.sample_valid), 32'h0);
        check_val("idle_left",  32'(s24.left), 32'h7FFFFF);
        check_val("idle_bck",   32'(bck24), 32'h0);
        en = 1'b1;
        repeat (256) @(negedge clk);
        check_val("restart_left",  32'(s24.left), 32'h800000);
        check_val("restart_right", 32'(s24.right), 32'h000000);
        check_val("restart_valid", 32'(s24.sample_valid), 32'h1);
        check_val("restart_ovr",   32'(overrun24), 32'h0);
`ifdef I2S_RX_MONO_EN
        check_val("mono_neg", 32'(s24.mono), 32'hC00000);
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
